// File: rtl/spi_pkg.sv
// Shared types, widths and frame helper for the SPI initiator.
package spi_pkg;

    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned BIT_CNT_W  = 5;

    localparam logic RW_READ = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        HOLD
    } state_t;

    // On-wire frame layout, MSB first.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              rw;
        logic [DATA_W-1:0] data;
    } frame_t;

    // Reads send zeros in the data phase so the slave sees a clean line.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [ADDR_W-1:0] a,
        input logic              rw,
        input logic [DATA_W-1:0] d
    );
        frame_t f;
        f.addr = a;
        f.rw   = rw;
        f.data = (rw == RW_READ) ? '0 : d;
        return f;
    endfunction

endpackage

// File: rtl/sclk_divider.sv
// SCLK half-period generator; rise/fall strobes mark the clk edge on which
// the registered s_clk level changes.
module sclk_divider #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic rise_tick,
    output logic fall_tick,
    output logic s_clk
);

    localparam int unsigned CNT_W = $clog2(HALF_DIV);

    logic [CNT_W-1:0] cnt;
    logic             half_c;

    // Counter sits at 0 while stopped, so a tick can never fire when idle.
    assign half_c    = (cnt == CNT_W'(HALF_DIV - 1));
    assign rise_tick = half_c && !s_clk;
    assign fall_tick = half_c &&  s_clk;

    // Half-period counter and SCLK level; both restart whenever run drops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            s_clk <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            s_clk <= 1'b0;
        end else if (half_c) begin
            cnt   <= '0;
            s_clk <= ~s_clk;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one 16-bit frame (addr, r/w, data) per start request.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              miso,
    output logic              CS,
    output logic              s_clk,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    state_t state, state_nxt;

    logic [FRAME_BITS-1:0] tx_sr, tx_nxt;
    logic [DATA_W-1:0]     rx_sr, rx_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic                  rw_q, rw_nxt;
    logic                  cs_nxt, busy_nxt, done_nxt;
    logic [DATA_W-1:0]     rdata_nxt;

    logic rise_tick, fall_tick, run_c;

    // Divider stops on the HOLD-exit tick so s_clk never pulses high there.
    assign run_c = (state != IDLE) && !((state == HOLD) && rise_tick);

    sclk_divider #(
        .HALF_DIV (HALF_DIV)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run_c),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .s_clk     (s_clk)
    );

    // mosi is the MSB of the tx shift register; zero-fill returns it to 0 at the end.
    assign mosi = tx_sr[FRAME_BITS-1];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-value logic for the frame sequencer.
    always_comb begin
        state_nxt = state;
        tx_nxt    = tx_sr;
        rx_nxt    = rx_sr;
        cnt_nxt   = bit_cnt;
        rw_nxt    = rw_q;
        cs_nxt    = CS;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        rdata_nxt = rdata;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = START;
                    tx_nxt    = build_frame(addr, read_write, wdata);
                    rx_nxt    = '0;
                    cnt_nxt   = '0;
                    rw_nxt    = read_write;
                    cs_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (rise_tick && (rw_q == RW_READ) && (bit_cnt >= BIT_CNT_W'(DATA_W))) begin
                    rx_nxt = {rx_sr[DATA_W-2:0], miso};
                end
                if (fall_tick) begin
                    tx_nxt  = {tx_sr[FRAME_BITS-2:0], 1'b0};
                    cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (rise_tick) begin
                    state_nxt = IDLE;
                    cs_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    if (rw_q == RW_READ) begin
                        rdata_nxt = rx_sr;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            rw_q    <= 1'b0;
            CS      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            tx_sr   <= tx_nxt;
            rx_sr   <= rx_nxt;
            bit_cnt <= cnt_nxt;
            rw_q    <= rw_nxt;
            CS      <= cs_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            rdata   <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table plus multi-cycle corner sequences.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1 (HALF_DIV = 4)
    logic       reset_n, start, read_write;
    logic       miso = 1'b0;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       cs, s_clk, mosi, busy, done;
    logic [7:0] rdata;

    // DUT 2 (HALF_DIV = 2)
    logic       start2, read_write2;
    logic       miso2 = 1'b0;
    logic [6:0] addr2;
    logic [7:0] wdata2;
    logic       cs2, s_clk2, mosi2, busy2, done2;
    logic [7:0] rdata2;

    spi_master #(.HALF_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .read_write(read_write),
        .addr(addr), .wdata(wdata), .miso(miso), .CS(cs), .s_clk(s_clk),
        .mosi(mosi), .busy(busy), .done(done), .rdata(rdata)
    );

    spi_master #(.HALF_DIV(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .read_write(read_write2),
        .addr(addr2), .wdata(wdata2), .miso(miso2), .CS(cs2), .s_clk(s_clk2),
        .mosi(mosi2), .busy(busy2), .done(done2), .rdata(rdata2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Slave model / monitor for DUT 1: records mosi at s_clk rises, drives miso after falls.
    logic [7:0]  slave_byte = 8'h00;
    logic [15:0] cap_bits   = 16'h0;
    int          fall_cnt   = 0;
    int          done_cnt   = 0;
    logic        prev_cs    = 1'b1;
    logic        prev_sclk  = 1'b0;

    always @(negedge clk) begin
        logic [15:0] f;
        if (!cs && prev_cs) begin
            cap_bits = 16'h0;
            fall_cnt = 0;
        end
        if (!cs) begin
            if (s_clk && !prev_sclk) cap_bits = {cap_bits[14:0], mosi};
            if (!s_clk && prev_sclk) fall_cnt++;
        end
        if (done) done_cnt++;
        f = {8'h00, slave_byte};
        miso = (!cs && fall_cnt < 16) ? f[4'(15 - fall_cnt)] : 1'b0;
        prev_cs   = cs;
        prev_sclk = s_clk;
    end

    // Same slave model for DUT 2.
    logic [7:0]  slave_byte2 = 8'h00;
    logic [15:0] cap_bits2   = 16'h0;
    int          fall_cnt2   = 0;
    int          done_cnt2   = 0;
    logic        prev_cs2    = 1'b1;
    logic        prev_sclk2  = 1'b0;

    always @(negedge clk) begin
        logic [15:0] f;
        if (!cs2 && prev_cs2) begin
            cap_bits2 = 16'h0;
            fall_cnt2 = 0;
        end
        if (!cs2) begin
            if (s_clk2 && !prev_sclk2) cap_bits2 = {cap_bits2[14:0], mosi2};
            if (!s_clk2 && prev_sclk2) fall_cnt2++;
        end
        if (done2) done_cnt2++;
        f = {8'h00, slave_byte2};
        miso2 = (!cs2 && fall_cnt2 < 16) ? f[4'(15 - fall_cnt2)] : 1'b0;
        prev_cs2   = cs2;
        prev_sclk2 = s_clk2;
    end

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  slave;
        int          inject;     // cycle after E0 at which a stray start is pulsed (0 = none)
        logic [15:0] exp_bits;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[5];

    // One full transaction on DUT 1 with all end-of-frame checks.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int d0;
        slave_byte = v.slave;
        @(negedge clk);
        read_write = v.rw;
        addr       = v.addr;
        wdata      = v.wdata;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_cs_e0"},   32'(cs),   32'h0);
        check({tag, "_busy_e0"}, 32'(busy), 32'h1);
        check({tag, "_mosi_e0"}, 32'(mosi), 32'(v.exp_bits[15]));
        d0  = done_cnt;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            if (v.inject != 0 && n == v.inject) begin
                start      = 1'b1;
                addr       = 7'h11;
                read_write = ~v.rw;
                wdata      = 8'h5A;
            end
            if (v.inject != 0 && n == v.inject + 1) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_latency"},  32'(lat),      32'd132);
        check({tag, "_cs_done"},  32'(cs),       32'h1);
        check({tag, "_busy_done"},32'(busy),     32'h0);
        check({tag, "_sclk_done"},32'(s_clk),    32'h0);
        check({tag, "_rdata"},    32'(rdata),    32'(v.exp_rdata));
        check({tag, "_bits"},     32'(cap_bits), 32'(v.exp_bits));
        repeat (40) @(posedge clk);
        #1;
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_cs_after"},   32'(cs),             32'h1);
    endtask

    initial begin
        int lat;
        int d0;
        vec_t fresh;

        vecs[0] = '{1'b0, 7'h2A, 8'hC3, 8'h00, 0,  16'h54C3, 8'h00};
        vecs[1] = '{1'b1, 7'h05, 8'hFF, 8'hA5, 0,  16'h0B00, 8'hA5};
        vecs[2] = '{1'b0, 7'h7F, 8'h00, 8'hFF, 0,  16'hFE00, 8'hA5};
        vecs[3] = '{1'b1, 7'h00, 8'h77, 8'h3C, 0,  16'h0100, 8'h3C};
        vecs[4] = '{1'b0, 7'h55, 8'hAA, 8'h00, 40, 16'hAAAA, 8'h3C};

        reset_n = 1'b0; start = 1'b0; read_write = 1'b0; addr = '0; wdata = '0;
        start2 = 1'b0; read_write2 = 1'b0; addr2 = '0; wdata2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs",    32'(cs),    32'h1);
        check("rst_sclk",  32'(s_clk), 32'h0);
        check("rst_mosi",  32'(mosi),  32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_cs2",   32'(cs2),   32'h1);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: start held high through done.
        slave_byte = 8'h00;
        @(negedge clk);
        read_write = 1'b0; addr = 7'h33; wdata = 8'h0F; start = 1'b1;
        @(posedge clk);
        #1;
        d0  = done_cnt;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("b2b_latency1", 32'(lat), 32'd132);
        check("b2b_cs_gap",   32'(cs),  32'h1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_cs_refall", 32'(cs),   32'h0);
        check("b2b_busy2",     32'(busy), 32'h1);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("b2b_latency2", 32'(lat),      32'd132);
        check("b2b_bits2",    32'(cap_bits), 32'h660F);
        repeat (20) @(posedge clk);
        #1;
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_cs_after",   32'(cs),            32'h1);

        // Reset mid-frame at E0+50.
        @(negedge clk);
        read_write = 1'b0; addr = 7'h7F; wdata = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("midrst_pre_mosi", 32'(mosi), 32'h1);
        reset_n = 1'b0;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        check("midrst_cs",    32'(cs),    32'h1);
        check("midrst_sclk",  32'(s_clk), 32'h0);
        check("midrst_mosi",  32'(mosi),  32'h0);
        check("midrst_busy",  32'(busy),  32'h0);
        check("midrst_done",  32'(done),  32'h0);
        check("midrst_rdata", 32'(rdata), 32'h0);
        reset_n = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_cs_idle", 32'(cs),            32'h1);
        fresh = '{1'b0, 7'h2A, 8'hC3, 8'h00, 0, 16'h54C3, 8'h00};
        run_vec(fresh, "post_rst");

        // HALF_DIV = 2 read: address 0x3C, slave returns 0x3C.
        slave_byte2 = 8'h3C;
        @(negedge clk);
        read_write2 = 1'b1; addr2 = 7'h3C; wdata2 = 8'hEE; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("h2_cs_e0", 32'(cs2), 32'h0);
        d0  = done_cnt2;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                lat = n;
                break;
            end
        end
        check("h2_latency", 32'(lat),       32'd66);
        check("h2_rdata",   32'(rdata2),    32'h3C);
        check("h2_busy",    32'(busy2),     32'h0);
        check("h2_bits",    32'(cap_bits2), 32'h7900);
        repeat (10) @(posedge clk);
        #1;
        check("h2_done_count", 32'(done_cnt2 - d0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

Host-side SPI initiator that drives the SPI memory's slave FSM from the other end of the link. It accepts a single-transaction request (7-bit address, R/W, write byte), produces CS/SCLK/MOSI in SPI mode 0, and for reads captures the returned byte from MISO. It sits between the lab's control logic and the external SPI pins, and is used as the stimulus source for the slave-side datapath.

## Interface
- HALF_DIV, 4, system `clk` cycles per SCLK half-period; legal range ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only while idle.
- read_write  in  1  1 = read, 0 = write; latched with `start`.
- addr  in  7  memory address; latched with `start`.
- wdata  in  8  write byte; latched with `start`, ignored for reads.
- miso  in  1  serial data from slave.
- CS  out  1  chip select, active low; reset 1.
- s_clk  out  1  SPI clock, idles low; reset 0.
- mosi  out  1  serial data to slave; reset 0.
- busy  out  1  high from accepted `start` until `done`; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- rdata  out  8  last byte read; reset 0x00.

## Operation
- Frame: 16 bits, MSB first, with `addr[6:0]` followed by the `read_write` bit, then 8 data bits.
- Write: the data bits are `wdata[7:0]` on mosi.
- Read: mosi is 0 for all data bits; miso is shifted in on each of the last 8 SCLK rising edges.
- Mode 0 timing:
  - mosi changes on SCLK falling edges, and on CS assertion for bit 15.
  - The slave samples on rising edges.
  - miso is captured from the value present at the clk edge on which s_clk is registered high.
- States, held in registers:
  - IDLE → START: on `start`; latch the request, CS=0, mosi=addr[6], busy=1.
  - START → SHIFT.
  - SHIFT: 16 rising/falling pairs.
  - SHIFT → HOLD: after the 16th falling edge.
  - HOLD → IDLE: after one half-period; CS=1, busy=0, done=1.
- rdata updates at `done` only for reads; writes leave rdata unchanged.
- `start` while busy is ignored and not queued.
- `start` held high through `done` launches a new transaction on the cycle after `done`, because the FSM is idle again then.
- Reset (reset_n=0 sampled at a clk edge) at any point, including mid-frame:
  - On that edge, all outputs return to their reset values and the FSM goes to IDLE.
  - No `done` pulse; the partial frame is abandoned.

## Timing
- Let E0 be the clk edge that accepts `start`, and H = HALF_DIV.
- From E0: CS=0, busy=1, mosi=bit 15.
- s_clk rising edge k (k=0..15) at E0 + H + 2kH.
- Falling edge k at E0 + 2H + 2kH; mosi moves to the next bit there, except after the last bit, where mosi returns to 0.
- Last falling edge at E0 + 32H.
- CS=1, done=1, busy=0, rdata valid: at E0 + 33H. With H=4, that is 132 cycles.
- All outputs are registered; no combinational path from any input to any output.
- CS setup to the first s_clk rise is H cycles; s_clk-low hold to CS deassert is H cycles.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, START, SHIFT, HOLD);
  - ADDR_W=7, DATA_W=8, FRAME_BITS=16;
  - RW_READ=1'b1.
- Sub-module `sclk_divider`:
  - parameter HALF_DIV, ports clk, reset_n, run;
  - outputs one-cycle `rise_tick`/`fall_tick` strobes and the s_clk level;
  - counter restarts whenever run=0.
- The top level holds the FSM, the 16-bit tx shift register, the 8-bit rx shift register and the 5-bit bit counter.

## Test plan
- Write, H=4: start with addr=0x2A, read_write=0, wdata=0xC3.
  - mosi sampled at the 16 s_clk rises = 0101010_0_11000011.
  - done at E0+132, rdata remains 0x00.
- Read: addr=0x05, read_write=1; bench slave drives 0xA5 on miso, changing on falling edges.
  - Rise-samples give 0000101_1 then zeros.
  - rdata=0xA5 at done; busy=0 the same cycle.
- Ignored start: pulse `start` with different addr at E0+40 during a transfer.
  - Frame bits are unchanged.
  - Exactly one done pulse.
- Back-to-back: `start` held high.
  - Second CS fall one cycle after the first done.
  - CS high for exactly that one cycle.
- Reset mid-frame: reset_n=0 at E0+50 for one cycle.
  - Next edge: CS=1, s_clk=0, mosi=0, busy=0, rdata=0x00.
  - No done pulse.
  - A fresh write then completes normally.
- HALF_DIV=2: a read of 0x3C completes at E0+66 with correct rdata.
